wb_write_arbiter: RTL and testbench

- Writeback stage sitting directly upstream of RegisterFile; the single source that drives its write port (regwrite, regdst, writedata).
- Merges single-cycle ALU results with results from multi-cycle units (load/multiply) through a small FIFO.
- Maintains a per-register pending scoreboard that decode uses to stall on outstanding multi-cycle results.

---
 rtl/wb_write_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_write_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: owns the RegisterFile write port, merging ALU results with a small
// FIFO of multi-cycle results, and tracks outstanding slow writes in a pending scoreboard.
module wb_write_arbiter #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_dst,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_stall,
    input  logic                 slow_valid,
    output logic                 slow_ready,
    input  logic [ADDR_W-1:0]    slow_dst,
    input  logic [DATA_W-1:0]    slow_data,
    input  logic                 mark_valid,
    input  logic [ADDR_W-1:0]    mark_dst,
    output logic                 regwrite,
    output logic [ADDR_W-1:0]    regdst,
    output logic [DATA_W-1:0]    writedata,
    output logic [2**ADDR_W-1:0] pending
);

    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned StW   = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned NRegs = 2**ADDR_W;

    logic [ADDR_W-1:0] fifo_dst_q  [DEPTH];
    logic [ADDR_W-1:0] fifo_dst_d  [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_d [DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [StW-1:0]    starve_q, starve_d;
    logic              alu_stall_q, alu_stall_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] regdst_q, regdst_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              slow_commit_q, slow_commit_d;
    logic [NRegs-1:0]  pending_q, pending_d;

    logic push, pop, alu_win, fifo_nonempty;

    always_comb begin
        slow_ready    = !rst && (count_q != CntW'(DEPTH));
        fifo_nonempty = (count_q != '0);
        alu_win       = alu_valid && !alu_stall_q;
        pop           = !alu_win && fifo_nonempty;
        push          = slow_valid && slow_ready;
    end

    // Write-port selection: ALU first, then FIFO head, otherwise idle with held data.
    always_comb begin
        regwrite_d    = 1'b0;
        regdst_d      = regdst_q;
        writedata_d   = writedata_q;
        slow_commit_d = 1'b0;
        if (alu_win) begin
            regwrite_d  = 1'b1;
            regdst_d    = alu_dst;
            writedata_d = alu_data;
        end else if (pop) begin
            regwrite_d    = 1'b1;
            regdst_d      = fifo_dst_q[rd_ptr_q];
            writedata_d   = fifo_data_q[rd_ptr_q];
            slow_commit_d = 1'b1;
        end
    end

    // Counts ALU wins over a waiting FIFO; the stall forces exactly one pop.
    always_comb begin
        starve_d    = '0;
        alu_stall_d = 1'b0;
        if (alu_win && fifo_nonempty) begin
            starve_d    = starve_q + StW'(1);
            alu_stall_d = (starve_d == StW'(STARVE_LIMIT));
        end
    end

    always_comb begin
        fifo_dst_d  = fifo_dst_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_dst_d[wr_ptr_q]  = slow_dst;
            fifo_data_d[wr_ptr_q] = slow_data;
            wr_ptr_d              = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear on the commit edge, then set, so a coincident mark wins.
    always_comb begin
        pending_d = pending_q;
        if (regwrite_q && slow_commit_q) begin
            pending_d[regdst_q] = 1'b0;
        end
        if (mark_valid) begin
            pending_d[mark_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            starve_q      <= '0;
            alu_stall_q   <= 1'b0;
            regwrite_q    <= 1'b0;
            regdst_q      <= '0;
            writedata_q   <= '0;
            slow_commit_q <= 1'b0;
            pending_q     <= '0;
        end else begin
            fifo_dst_q    <= fifo_dst_d;
            fifo_data_q   <= fifo_data_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            starve_q      <= starve_d;
            alu_stall_q   <= alu_stall_d;
            regwrite_q    <= regwrite_d;
            regdst_q      <= regdst_d;
            writedata_q   <= writedata_d;
            slow_commit_q <= slow_commit_d;
            pending_q     <= pending_d;
        end
    end

    assign alu_stall = alu_stall_q;
    assign regwrite  = regwrite_q;
    assign regdst    = regdst_q;
    assign writedata = writedata_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue-based reference model.
module tb_wb_write_arbiter;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 4;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;
    logic              slow_valid;
    logic              slow_ready;
    logic [ADDR_W-1:0] slow_dst;
    logic [DATA_W-1:0] slow_data;
    logic              mark_valid;
    logic [ADDR_W-1:0] mark_dst;
    logic              regwrite;
    logic [ADDR_W-1:0] regdst;
    logic [DATA_W-1:0] writedata;
    logic [15:0]       pending;

    wb_write_arbiter #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_dst   (alu_dst),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .slow_valid(slow_valid),
        .slow_ready(slow_ready),
        .slow_dst  (slow_dst),
        .slow_data (slow_data),
        .mark_valid(mark_valid),
        .mark_dst  (mark_dst),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .writedata (writedata),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } ent_t;

    // Reference model: queued slow results, consecutive-bypass count, presented write.
    ent_t              q[$];
    int                m_bypass = 0;
    logic              m_stall  = 1'b0;
    logic              m_rw     = 1'b0;
    logic              m_slow   = 1'b0;
    logic [ADDR_W-1:0] m_dst    = '0;
    logic [DATA_W-1:0] m_data   = '0;
    logic [15:0]       m_pend   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        ent_t e;
        bit   accept;
        if (rst) begin
            q.delete();
            m_bypass = 0;
            m_stall  = 1'b0;
            m_rw     = 1'b0;
            m_slow   = 1'b0;
            m_dst    = '0;
            m_data   = '0;
            m_pend   = '0;
            return;
        end
        if (m_rw && m_slow) m_pend[m_dst] = 1'b0;
        if (mark_valid) m_pend[mark_dst] = 1'b1;
        accept = slow_valid && (q.size() < DEPTH);
        if (alu_valid && !m_stall) begin
            m_rw     = 1'b1;
            m_slow   = 1'b0;
            m_dst    = alu_dst;
            m_data   = alu_data;
            m_bypass = (q.size() > 0) ? m_bypass + 1 : 0;
            m_stall  = (m_bypass >= STARVE_LIMIT);
        end else if (q.size() > 0) begin
            e        = q.pop_front();
            m_rw     = 1'b1;
            m_slow   = 1'b1;
            m_dst    = e.dst;
            m_data   = e.data;
            m_bypass = 0;
            m_stall  = 1'b0;
        end else begin
            m_rw     = 1'b0;
            m_slow   = 1'b0;
            m_bypass = 0;
            m_stall  = 1'b0;
        end
        if (accept) begin
            e.dst  = slow_dst;
            e.data = slow_data;
            q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("regwrite", 32'(regwrite), 32'(m_rw));
            check("regdst", 32'(regdst), 32'(m_dst));
            check("writedata", 32'(writedata), 32'(m_data));
            check("pending", 32'(pending), 32'(m_pend));
            check("alu_stall", 32'(alu_stall), 32'(m_stall));
            check("slow_ready", 32'(slow_ready), 32'(!rst && (q.size() < DEPTH)));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        alu_valid  = 1'b0;
        slow_valid = 1'b0;
        mark_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alu_dst = '0;
        alu_data = '0;
        slow_dst = '0;
        slow_data = '0;
        mark_dst = '0;
        idle();
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_regwrite", 32'(regwrite), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_alu_stall", 32'(alu_stall), 0);
        check("rst_slow_ready", 32'(slow_ready), 0);
        rst = 1'b0;
        #1;
        check("post_rst_slow_ready", 32'(slow_ready), 1);

        // ALU write to r0, latency 1; data holds while idle
        alu_valid = 1'b1; alu_dst = 4'd0; alu_data = 16'h0007;
        tick();
        idle();
        check("alu_rw", 32'(regwrite), 1);
        check("alu_dst", 32'(regdst), 0);
        check("alu_data", 32'(writedata), 32'h0007);
        check("alu_pending", 32'(pending), 0);
        tick();
        check("idle_rw", 32'(regwrite), 0);
        check("idle_hold_data", 32'(writedata), 32'h0007);

        // Slow path with scoreboard
        mark_valid = 1'b1; mark_dst = 4'd5;
        tick();
        idle();
        check("mark_pending", 32'(pending), 32'h0020);
        tick();
        tick();
        slow_valid = 1'b1; slow_dst = 4'd5; slow_data = 16'h0024;
        tick();
        idle();
        check("slow_no_bypass", 32'(regwrite), 0);
        tick();
        check("slow_rw", 32'(regwrite), 1);
        check("slow_dst", 32'(regdst), 5);
        check("slow_data", 32'(writedata), 32'h0024);
        check("slow_pending_held", 32'(pending), 32'h0020);
        tick();
        check("slow_pending_clr", 32'(pending), 0);

        // Collision: ALU first, slow next
        alu_valid = 1'b1; alu_dst = 4'd1; alu_data = 16'h0011;
        slow_valid = 1'b1; slow_dst = 4'd2; slow_data = 16'h0022;
        tick();
        idle();
        check("coll_t1_dst", 32'(regdst), 1);
        check("coll_t1_data", 32'(writedata), 32'h0011);
        tick();
        check("coll_t2_rw", 32'(regwrite), 1);
        check("coll_t2_dst", 32'(regdst), 2);
        check("coll_t2_data", 32'(writedata), 32'h0022);
        tick();

        // FIFO full and starvation pulse
        alu_valid = 1'b1; alu_dst = 4'd7; alu_data = 16'h0077;
        for (int i = 0; i < 4; i++) begin
            slow_valid = 1'b1;
            slow_dst   = 4'(8 + i);
            slow_data  = 16'(16'h0100 + i);
            tick();
        end
        slow_valid = 1'b0;
        check("full_slow_ready", 32'(slow_ready), 0);
        check("full_no_stall_yet", 32'(alu_stall), 0);
        tick();
        check("starve_stall", 32'(alu_stall), 1);
        check("starve_alu_dst", 32'(regdst), 7);
        tick();
        check("starve_stall_drop", 32'(alu_stall), 0);
        check("starve_head_dst", 32'(regdst), 8);
        check("starve_head_data", 32'(writedata), 32'h0100);
        tick();
        check("starve_alu_after", 32'(regdst), 7);
        idle();
        for (int i = 0; i < 4; i++) tick();

        // Simultaneous set and clear of r3
        mark_valid = 1'b1; mark_dst = 4'd3;
        tick();
        idle();
        slow_valid = 1'b1; slow_dst = 4'd3; slow_data = 16'h0033;
        tick();
        idle();
        tick();
        check("setclr_rw_dst", 32'(regdst), 3);
        mark_valid = 1'b1; mark_dst = 4'd3;
        tick();
        idle();
        check("setclr_pending3", 32'(pending[3]), 1);

        // Mid-operation reset with 3 queued entries
        alu_valid = 1'b1; alu_dst = 4'd6; alu_data = 16'h0066;
        mark_valid = 1'b1; mark_dst = 4'd5;
        slow_valid = 1'b1; slow_dst = 4'd12; slow_data = 16'h00c0;
        tick();
        mark_valid = 1'b0;
        slow_dst = 4'd13; slow_data = 16'h00d0;
        tick();
        slow_dst = 4'd14; slow_data = 16'h00e0;
        tick();
        check("mid_pending", 32'(pending), 32'h0028);
        rst = 1'b1;
        #1;
        check("mid_rst_slow_ready", 32'(slow_ready), 0);
        tick();
        check("mid_rst_rw", 32'(regwrite), 0);
        check("mid_rst_pending", 32'(pending), 0);
        rst = 1'b0;
        idle();
        #1;
        check("mid_rst_ready_after", 32'(slow_ready), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_write", 32'(regwrite), 0);
        end

        // Random traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r;
            if (!m_stall) begin
                alu_valid = ($urandom_range(0, 9) < 6);
                alu_dst   = 4'($urandom_range(0, 15));
                alu_data  = 16'($urandom);
            end
            slow_valid = ($urandom_range(0, 9) < 4);
            slow_dst   = 4'($urandom_range(0, 15));
            slow_data  = 16'($urandom);
            r          = $urandom_range(0, 15);
            mark_dst   = 4'(r);
            mark_valid = ($urandom_range(0, 9) < 3) && !m_pend[r];
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
